// File: rtl/generic_cla.sv
// Two-level carry-lookahead adder with a registered result and a valid flag.
// The lookahead cell is shared by the per-group level and the top level.

module cla_lookahead #(
  parameter int N = 4
) (
  input  logic [N-1:0] i_g,
  input  logic [N-1:0] i_p,
  input  logic         i_cin,
  output logic [N-1:0] o_c,
  output logic         o_gen,
  output logic         o_prop
);

  // Each carry is written out as its own flat sum-of-products; nothing chains carry to carry.
  always_comb begin
    logic w_prod;
    o_c    = {N{1'b0}};
    o_gen  = 1'b0;
    o_prop = 1'b1;
    w_prod = 1'b0;
    o_c[0] = i_cin;
    for (int j = 1; j < N; j++) begin
      for (int k = 0; k < j; k++) begin
        w_prod = i_g[k];
        for (int m = 0; m < N; m++) begin
          if (m > k && m < j) begin
            w_prod = w_prod & i_p[m];
          end else begin
            w_prod = w_prod;
          end
        end
        o_c[j] = o_c[j] | w_prod;
      end
      w_prod = i_cin;
      for (int m = 0; m < N; m++) begin
        if (m < j) begin
          w_prod = w_prod & i_p[m];
        end else begin
          w_prod = w_prod;
        end
      end
      o_c[j] = o_c[j] | w_prod;
    end
    for (int k = 0; k < N; k++) begin
      w_prod = i_g[k];
      for (int m = 0; m < N; m++) begin
        if (m > k) begin
          w_prod = w_prod & i_p[m];
        end else begin
          w_prod = w_prod;
        end
      end
      o_gen  = o_gen | w_prod;
      o_prop = o_prop & i_p[k];
    end
  end

endmodule

module generic_cla #(
  parameter int WIDTH = 4,
  parameter int GROUP = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c0,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             pg,
  output logic             gg,
  output logic             out_valid
);

  localparam int NG = WIDTH / GROUP;

  logic [WIDTH-1:0] w_p;
  logic [WIDTH-1:0] w_g;
  logic [WIDTH-1:0] w_c;
  logic [NG-1:0]    w_grp_p;
  logic [NG-1:0]    w_grp_g;
  logic [NG-1:0]    w_grp_cin;
  logic             w_top_g;
  logic             w_top_p;

  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_pg;
  logic             r_gg;
  logic             r_out_valid;

  assign w_p = a ^ b;
  assign w_g = a & b;

  for (genvar gi = 0; gi < NG; gi++) begin : g_grp
    cla_lookahead #(.N(GROUP)) u_grp (
      .i_g    (w_g[gi*GROUP +: GROUP]),
      .i_p    (w_p[gi*GROUP +: GROUP]),
      .i_cin  (w_grp_cin[gi]),
      .o_c    (w_c[gi*GROUP +: GROUP]),
      .o_gen  (w_grp_g[gi]),
      .o_prop (w_grp_p[gi])
    );
  end

  // Group carry-ins from group P/G; with a single group this reduces to c0.
  cla_lookahead #(.N(NG)) u_top (
    .i_g    (w_grp_g),
    .i_p    (w_grp_p),
    .i_cin  (c0),
    .o_c    (w_grp_cin),
    .o_gen  (w_top_g),
    .o_prop (w_top_p)
  );

  // Result register: cleared by reset, loaded on valid, held otherwise.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sum       <= {WIDTH{1'b0}};
      r_cout      <= 1'b0;
      r_pg        <= 1'b0;
      r_gg        <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= in_valid;
      if (in_valid) begin
        r_sum  <= w_p ^ w_c;
        r_cout <= w_top_g | (w_top_p & c0);
        r_pg   <= w_top_p;
        r_gg   <= w_top_g;
      end else begin
        r_sum  <= r_sum;
        r_cout <= r_cout;
        r_pg   <= r_pg;
        r_gg   <= r_gg;
      end
    end
  end

  assign sum       = r_sum;
  assign cout      = r_cout;
  assign pg        = r_pg;
  assign gg        = r_gg;
  assign out_valid = r_out_valid;

endmodule

// File: tb/tb_generic_cla.sv
// Bench for generic_cla: directed vector table, hold/reset sequences,
// exhaustive 4-bit sweep and a random 16-bit sweep against an arithmetic model.

module tb_generic_cla;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        in_valid;
  logic [3:0]  a4, b4;
  logic        c4;
  logic [3:0]  sum4;
  logic        cout4, pg4, gg4, ov4;
  logic [15:0] a16, b16;
  logic        c16;
  logic [15:0] sum16;
  logic        cout16, pg16, gg16, ov16;

  generic_cla #(.WIDTH(4), .GROUP(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a4), .b(b4), .c0(c4),
    .sum(sum4), .cout(cout4), .pg(pg4), .gg(gg4), .out_valid(ov4)
  );

  generic_cla #(.WIDTH(16), .GROUP(4)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a16), .b(b16), .c0(c16),
    .sum(sum16), .cout(cout16), .pg(pg16), .gg(gg16), .out_valid(ov16)
  );

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic check4(input string tag, input logic [3:0] s, input logic co,
                        input logic p, input logic g, input logic v);
    check({tag, ".sum"}, 32'(sum4), 32'(s));
    check({tag, ".cout"}, 32'(cout4), 32'(co));
    check({tag, ".pg"}, 32'(pg4), 32'(p));
    check({tag, ".gg"}, 32'(gg4), 32'(g));
    check({tag, ".valid"}, 32'(ov4), 32'(v));
  endtask

  // Reference: plain integer addition; pg/gg from their arithmetic meaning.
  function automatic logic [19:0] model(input int w, input logic [15:0] a, input logic [15:0] b,
                                        input logic c);
    logic [16:0] full, nocarry, mask;
    logic p, g;
    mask    = (17'd1 << w) - 17'd1;
    full    = 17'(a) + 17'(b) + 17'(c);
    nocarry = 17'(a) + 17'(b);
    p       = ((17'(a) ^ 17'(b)) & mask) == mask;
    g       = ((nocarry >> w) & 17'd1) == 17'd1;
    return {1'b0, p, g, full};
  endfunction

  typedef struct {
    logic [3:0] a, b;
    logic       c0;
    logic [3:0] sum;
    logic       cout, pg, gg;
  } vec_t;

  vec_t tbl[7];

  initial begin
    logic [19:0] e4, e16;
    logic        have_prev;
    tbl[0] = '{4'h0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{4'h5, 4'h3, 1'b0, 4'h8, 1'b0, 1'b0, 1'b0};
    tbl[2] = '{4'hF, 4'h1, 1'b0, 4'h0, 1'b1, 1'b0, 1'b1};
    tbl[3] = '{4'hA, 4'h5, 1'b1, 4'h0, 1'b1, 1'b1, 1'b0};
    tbl[4] = '{4'h7, 4'h8, 1'b1, 4'h0, 1'b1, 1'b1, 1'b0};
    tbl[5] = '{4'h9, 4'h6, 1'b0, 4'hF, 1'b0, 1'b1, 1'b0};
    tbl[6] = '{4'hF, 4'hF, 1'b1, 4'hF, 1'b1, 1'b0, 1'b1};

    // Reset held with valid input present: the input must be discarded.
    rst_n = 1'b0; in_valid = 1'b1;
    a4 = 4'hF; b4 = 4'hF; c4 = 1'b1;
    a16 = 16'hFFFF; b16 = 16'hFFFF; c16 = 1'b1;
    repeat (2) @(negedge clk);
    check4("reset", 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("reset16.sum", 32'(sum16), 32'd0);
    check("reset16.valid", 32'(ov16), 32'd0);

    // Table applied back-to-back; first entry goes in on the first edge out of reset.
    rst_n = 1'b1;
    a16 = 16'h0; b16 = 16'h0; c16 = 1'b0;
    for (int i = 0; i < 7; i++) begin
      a4 = tbl[i].a; b4 = tbl[i].b; c4 = tbl[i].c0;
      @(negedge clk);
      check4($sformatf("tbl%0d", i), tbl[i].sum, tbl[i].cout, tbl[i].pg, tbl[i].gg, 1'b1);
    end

    // Idle cycles: valid drops, result of F+F+1 stays put.
    in_valid = 1'b0; a4 = 4'h0; b4 = 4'h0; c4 = 1'b0;
    @(negedge clk);
    check4("hold1", 4'hF, 1'b1, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    check4("hold2", 4'hF, 1'b1, 1'b0, 1'b1, 1'b0);

    // Reset asserted mid-cycle must not touch outputs before the next edge.
    rst_n = 1'b0; in_valid = 1'b1;
    #1;
    check("rst_sync.sum", 32'(sum4), 32'hF);
    check("rst_sync.cout", 32'(cout4), 32'd1);
    @(negedge clk);
    check4("reset2", 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    check4("idle", 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Exhaustive 4-bit sweep alongside random 16-bit traffic, all back-to-back.
    have_prev = 1'b0;
    e4 = 20'h0; e16 = 20'h0;
    for (int i = 0; i < 512; i++) begin
      if (have_prev) begin
        check4("sweep4", e4[3:0], e4[4], e4[18], e4[17], 1'b1);
        check("sweep16.sum", 32'(sum16), 32'(e16[15:0]));
        check("sweep16.cout", 32'(cout16), 32'(e16[16]));
        check("sweep16.pg", 32'(pg16), 32'(e16[18]));
        check("sweep16.gg", 32'(gg16), 32'(e16[17]));
        check("sweep16.valid", 32'(ov16), 32'd1);
      end
      in_valid = 1'b1;
      a4 = 4'(i); b4 = 4'(i >> 4); c4 = 1'(i >> 8);
      case (i % 8)
        0: begin a16 = 16'hFFFF; b16 = 16'h0000; end
        1: begin a16 = 16'hFFFF; b16 = 16'hFFFF; end
        2: begin a16 = 16'hAAAA; b16 = 16'h5555; end
        3: begin a16 = 16'h0FFF; b16 = 16'h0001; end
        default: begin a16 = 16'($urandom); b16 = 16'($urandom); end
      endcase
      c16 = 1'($urandom);
      e4  = model(4, 16'(a4), 16'(b4), c4);
      e16 = model(16, a16, b16, c16);
      have_prev = 1'b1;
      @(negedge clk);
    end
    check4("sweep4", e4[3:0], e4[4], e4[18], e4[17], 1'b1);
    check("sweep16.sum", 32'(sum16), 32'(e16[15:0]));
    check("sweep16.cout", 32'(cout16), 32'(e16[16]));

    // A lone valid produces exactly one valid cycle.
    in_valid = 1'b0;
    @(negedge clk);
    check("pulse.valid_lo", 32'(ov4), 32'd0);
    check("pulse.hold16", 32'(sum16), 32'(e16[15:0]));
    in_valid = 1'b1; a4 = 4'h3; b4 = 4'h4; c4 = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check4("pulse", 4'h8, 1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    check4("pulse_end", 4'h8, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
